// File: rtl/match_pkg.sv
// Shared types and constants for the tug-of-war match sequencer and winner detector.
package match_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PLAY       = 2'd1,
        PAUSE      = 2'd2,
        MATCH_OVER = 2'd3
    } matchState_t;

    localparam logic WINNER_LEFT  = 1'b1;
    localparam logic WINNER_RIGHT = 1'b0;

endpackage

// File: rtl/score_counter.sv
// Per-player round counter: clear has priority over increment, reset over both.
module score_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    // NOTE: registers are written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/match_controller.sv
// Match-level sequencer: scores rounds, pauses between them and declares the match winner.
module match_controller
    import match_pkg::*;
#(
    parameter int WINS_TO_MATCH = 7,
    parameter int PAUSE_CYCLES  = 4,
    parameter int SCORE_W       = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               gameFinished,
    input  logic               winnerId,
    output logic               roundReset,
    output logic [SCORE_W-1:0] leftScore,
    output logic [SCORE_W-1:0] rightScore,
    output logic               lastWinner,
    output logic               matchOver,
    output logic               matchWinner
);

    localparam int PW = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
    localparam logic [PW-1:0]      PAUSE_LOAD = PW'(PAUSE_CYCLES - 1);
    localparam logic [SCORE_W-1:0] LAST_WIN   = SCORE_W'(WINS_TO_MATCH - 1);

    matchState_t   state;
    logic [PW-1:0] pauseCnt;

    logic roundEvent;
    logic incLeft;
    logic incRight;
    logic clearScores;
    logic winsMatch;

    // NOTE: pure continuous assigns cover every input combination, so no latch can appear.
    assign roundEvent  = (state == PLAY) && gameFinished;
    assign incLeft     = roundEvent && (winnerId == WINNER_LEFT);
    assign incRight    = roundEvent && (winnerId == WINNER_RIGHT);
    assign clearScores = (state == MATCH_OVER) && start;
    // The winner's current score is one short of the target, so this round ends the match.
    assign winsMatch   = (winnerId == WINNER_LEFT) ? (leftScore == LAST_WIN)
                                                   : (rightScore == LAST_WIN);

    assign roundReset = (state != PLAY);
    assign matchOver  = (state == MATCH_OVER);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            pauseCnt    <= '0;
            lastWinner  <= 1'b0;
            matchWinner <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state <= PLAY;
                end
                PLAY: begin
                    if (gameFinished) begin
                        lastWinner <= winnerId;
                        if (winsMatch) begin
                            state       <= MATCH_OVER;
                            matchWinner <= winnerId;
                        end else begin
                            state    <= PAUSE;
                            pauseCnt <= PAUSE_LOAD;
                        end
                    end
                end
                PAUSE: begin
                    if (pauseCnt == '0) state <= PLAY;
                    else                pauseCnt <= pauseCnt - PW'(1);
                end
                MATCH_OVER: begin
                    if (start) begin
                        state    <= PAUSE;
                        pauseCnt <= PAUSE_LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    score_counter #(.W(SCORE_W)) leftCounter (
        .clk   (clk),
        .reset (reset),
        .clear (clearScores),
        .inc   (incLeft),
        .count (leftScore)
    );

    score_counter #(.W(SCORE_W)) rightCounter (
        .clk   (clk),
        .reset (reset),
        .clear (clearScores),
        .inc   (incRight),
        .count (rightScore)
    );

endmodule

// File: doc/match_controller.md
# match_controller

Match-level sequencer for the two-player tug-of-war game. It consumes the one-cycle round-end pulse from the round winner detector and keeps a score per player. It holds the playfield and detector in reset between rounds for a fixed pause, and declares a match winner when a player reaches `WINS_TO_MATCH` rounds. It sits between the board-level button/start logic and the playfield LED chain plus winner detector, whose resets it drives.

## Interface

Parameters:
- `WINS_TO_MATCH`, default 7: rounds needed to win the match. Legal range is 1 to 2^`SCORE_W`-1.
- `PAUSE_CYCLES`, default 4: number of cycles `roundReset` is held between rounds. Must be ≥1.
- `SCORE_W`, default 3: width of each score counter.

Ports:
- `clk`, input, 1: system clock. All logic is on its rising edge.
- `reset`, input, 1: one clock; reset is synchronous and active-low. `reset`==0 sampled at a rising edge forces the reset state.
- `start`, input, 1: level-sampled start/restart request, already synchronised and debounced.
- `gameFinished`, input, 1: one-cycle pulse meaning a round was won.
- `winnerId`, input, 1: valid only with `gameFinished`. 1 = left player won the round, 0 = right player won the round.
- `roundReset`, output, 1: active-high reset to the playfield and winner detector.
- `leftScore`, output, `SCORE_W`: rounds won by the left player.
- `rightScore`, output, `SCORE_W`: rounds won by the right player.
- `lastWinner`, output, 1: `winnerId` of the most recently scored round.
- `matchOver`, output, 1: high while the match is decided.
- `matchWinner`, output, 1: 1 = left player, 0 = right player. Valid only while `matchOver`==1.

## Operation

States:
- **IDLE**
  - `roundReset`=1.
  - `start`=1 → PLAY.
  - Otherwise stay in IDLE.
- **PLAY**
  - `roundReset`=0.
  - `gameFinished`=1: increment the winner's score.
    - If the winner's new score == `WINS_TO_MATCH` → MATCH_OVER, and latch `matchWinner`=`winnerId`.
    - Otherwise → PAUSE, and load the pause counter with `PAUSE_CYCLES`-1.
  - `lastWinner` ← `winnerId` in both cases.
- **PAUSE**
  - `roundReset`=1.
  - The pause counter decrements each cycle.
  - At count 0 → PLAY.
- **MATCH_OVER**
  - `roundReset`=1, `matchOver`=1.
  - Scores and `matchWinner` are frozen.
  - `start`=1: clear both scores, clear `matchOver` → PAUSE with the counter loaded.

Rules:
- `gameFinished` outside PLAY is ignored: no score change, no state change.
- `start` in PLAY or PAUSE is ignored.
- Only one score increments per event. `winnerId` selects which one.
- Score arithmetic is unsigned `SCORE_W`-bit. The counters never wrap, because the match ends at `WINS_TO_MATCH` ≤ max count.
- Reset mid-match (any state) behaves as a full reset:
  - State → IDLE.
  - Scores, `lastWinner`, `matchWinner` and the pause counter → 0.
  - `matchOver` → 0, `roundReset` → 1.
  - Reset has priority over `start` and `gameFinished` in the same cycle.

## Timing

- State, scores, `lastWinner`, `matchWinner` and the pause counter are registers.
- `roundReset` and `matchOver` are Moore decodes of the state register. There is no combinational path from any input to any output.
- `gameFinished` sampled high at edge N causes the following at edge N+1:
  - The score is updated.
  - `lastWinner` is valid.
  - The state is PAUSE or MATCH_OVER, so `roundReset`=1 during cycle N+1.
- PAUSE lasts exactly `PAUSE_CYCLES` cycles. `roundReset` is high for exactly that many cycles before PLAY resumes.
- `start` sampled high in IDLE at edge N puts the block in PLAY during cycle N+1.
- `start` sampled high in MATCH_OVER at edge N gives cleared scores and PAUSE from cycle N+1, then PLAY after `PAUSE_CYCLES` cycles.
- Holding `start` high has no further effect: it is only acted on in IDLE and MATCH_OVER.

## Structure

- Package `match_pkg` holds:
  - The state enum (IDLE, PLAY, PAUSE, MATCH_OVER) with 2-bit encoding.
  - Constants `WINNER_LEFT`=1'b1 and `WINNER_RIGHT`=1'b0, shared with the winner detector.
- Sub-module `score_counter`:
  - Parameter `W`.
  - Inputs `clk`, `reset`, `clear`, `inc`. Output `count`.
  - Synchronous active-low reset.
  - Instantiated twice, once per player.
- The FSM and pause counter live in `match_controller`.

## Test plan

All cases use default parameters.

- **Reset:** hold `reset`=0 for 2 cycles.
  - Scores = 0, `roundReset`=1, `matchOver`=0, state IDLE.
  - `gameFinished` pulses in IDLE leave the scores at 0.
- **Start and single round:** `start` for 1 cycle, then a `gameFinished` pulse with `winnerId`=1.
  - Next cycle `leftScore`=1, `rightScore`=0, `lastWinner`=1.
  - `roundReset` is high for exactly 4 cycles, then low.
- **Ignored events:** a `gameFinished` pulse during PAUSE, and `start` during PLAY.
  - No score change.
  - PAUSE length is unchanged at 4.
- **Match win:** alternate wins to reach 6-6, then a right win.
  - `rightScore`=7, `matchOver`=1, `matchWinner`=0, `roundReset` held high.
  - A further pulse leaves the scores at 7/6.
- **Restart:** `start` during MATCH_OVER.
  - Scores go to 0/0 and `matchOver`=0 the next cycle.
  - 4 PAUSE cycles follow, then PLAY.
- **Reset mid-pause:** assert `reset`=0 at PAUSE count 2, with a score of 3/1.
  - Next cycle: IDLE, scores 0/0, `roundReset`=1.
